// File: rtl/gate_vector_sequencer.sv
// Walks {a,b} through 00,01,10,11, holds each vector for DWELL cycles, then
// checks seven observed gate outputs against the ideal truth table.
module gate_vector_sequencer #(
  parameter int unsigned DWELL = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       and_in,
  input  logic       nand_in,
  input  logic       or_in,
  input  logic       nor_in,
  input  logic       xor_in,
  input  logic       xnor_in,
  input  logic       not_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec,
  output logic [1:0] step
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // DRIVE | holding vector {a,b}=step while the dwell counter runs
  // CHECK | one-cycle compare of the observed gate outputs
  // DONE  | sweep finished, results held until the next start
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [7:0] dwell_q, dwell_d;
  logic [1:0] step_q, step_d;
  logic       a_q, a_d, b_q, b_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;

  logic [6:0] obs, expect_v;
  logic       mismatch;

  assign obs = {and_in, nand_in, or_in, nor_in, xor_in, xnor_in, not_in};

  // Written as a default-high flag so an unknown input compare leaves it set.
  always_comb begin
    expect_v = {a_q & b_q, ~(a_q & b_q), a_q | b_q, ~(a_q | b_q),
                a_q ^ b_q, ~(a_q ^ b_q), ~a_q};
    mismatch = 1'b1;
    if (obs == expect_v) mismatch = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (dwell_q == DWELL_LAST) state_d = CHECK;
      CHECK:   state_d = (step_q == 2'd3) ? DONE : DRIVE;
      DONE:    if (start) state_d = DRIVE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dwell_d = dwell_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dwell_d    = 8'd0;
          step_d     = 2'd0;
          {a_d, b_d} = 2'b00;
          err_d      = 3'd0;
          fail_d     = 4'd0;
        end
      end
      DRIVE: dwell_d = dwell_q + 8'd1;
      CHECK: begin
        // At most one count per vector, so err_count tops out at 4.
        if (mismatch) begin
          fail_d[step_q] = 1'b1;
          err_d          = err_q + 3'd1;
        end
        if (step_q != 2'd3) begin
          step_d     = step_q + 2'd1;
          {a_d, b_d} = step_q + 2'd1;
          dwell_d    = 8'd0;
        end else begin
          {a_d, b_d} = 2'b00;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q <= 8'd0;
      step_q  <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      dwell_q <= dwell_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    busy = (state_q == DRIVE) || (state_q == CHECK);
    done = (state_q == DONE);
    pass = (state_q == DONE) && (err_q == 3'd0);
  end

  assign a         = a_q;
  assign b         = b_q;
  assign step      = step_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule
